net_link_arbiter: RTL

- Shares one 16-bit network link among NUM_PORTS GPU network interfaces.
- Flit format is {dest_gpu[5:0], payload[9:0]}.
- Each GPU pulses its valid for one cycle and does not wait for ready, so every input has a small FIFO.
- A round-robin scheduler drains the FIFOs into a registered output stage with a valid/ready handshake toward the router, and counts drops per port.

---
 rtl/net_link_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/net_link_arbiter.sv
// Shares one flit link among NUM_PORTS GPU interfaces. Each port has a small input FIFO.
// A round-robin scheduler drains the FIFOs into a registered valid/ready output stage.
module net_link_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FLIT_W     = 16,
  parameter int CNT_W      = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_PORTS*FLIT_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [FLIT_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  out_src,
  output logic [NUM_PORTS*CNT_W-1:0]    drop_cnt,
  output logic                          idle
);

  localparam int SRC_W = $clog2(NUM_PORTS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [NUM_PORTS-1:0] w_push;
  logic [NUM_PORTS-1:0] w_pop;
  logic [NUM_PORTS-1:0] w_nonempty;
  logic [FLIT_W-1:0]    w_head [NUM_PORTS];

  logic                 w_slot_free;
  logic                 w_grant_vld;
  logic [SRC_W-1:0]     w_grant;
  logic                 w_load;

  logic                 r_vld_p1;
  logic [FLIT_W-1:0]    r_data_p1;
  logic [SRC_W-1:0]     r_src_p1;
  logic [SRC_W-1:0]     r_last;

  // Stage p0: per-port input FIFOs; fullness is always judged on the pre-edge count
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_cnt;
    logic [CNT_W-1:0]  r_drop;
    logic              w_full;

    assign w_full        = (r_cnt == CW'(FIFO_DEPTH));
    assign in_ready[i]   = !w_full;
    assign w_push[i]     = in_valid[i] && !w_full;
    assign w_pop[i]      = w_load && (w_grant == SRC_W'(i));
    assign w_nonempty[i] = (r_cnt != '0);
    assign w_head[i]     = r_mem[r_rptr];
    assign drop_cnt[i*CNT_W +: CNT_W] = r_drop;

    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_drop <= '0;
      end else begin
        if (w_push[i]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[i])  r_rptr <= r_rptr + 1'b1;
        unique case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
        if (in_valid[i] && w_full) r_drop <= sat_inc(r_drop);
      end
    end

    always_ff @(posedge ACLK) begin
      if (w_push[i]) r_mem[r_wptr] <= in_data[i*FLIT_W +: FLIT_W];
    end
  end

  // Round-robin search starting just after the last granted port
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int idx;
      idx = (int'(r_last) + k) % NUM_PORTS;
      if (!w_grant_vld && w_nonempty[SRC_W'(idx)]) begin
        w_grant_vld = 1'b1;
        w_grant     = SRC_W'(idx);
      end
    end
  end

  assign w_slot_free = !r_vld_p1 || out_ready;
  assign w_load      = w_slot_free && w_grant_vld;

  // Stage p1: registered output toward the router
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_src_p1  <= '0;
      r_last    <= SRC_W'(NUM_PORTS - 1);
    end else if (w_slot_free) begin
      if (w_grant_vld) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_head[w_grant];
        r_src_p1  <= w_grant;
        r_last    <= w_grant;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_src   = r_src_p1;
  assign idle      = !(|w_nonempty) && !r_vld_p1;

endmodule
